// File: rtl/debounce_defs_pkg.sv
// ---------------------------------------------------------------------------
// debounce_defs
//   Shared definitions for the latch input debouncer: the default stability
//   window and the FSM state encoding.
//
//   Contents:
//     DEFAULT_DEBOUNCE_CYCLES  default number of consecutive agreeing samples
//                              needed before a new level is accepted
//     state_t                  debouncer FSM states with fixed encodings
// ---------------------------------------------------------------------------
package debounce_defs;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,  // accepted level 0, input agrees
    ST_WAIT_HIGH = 2'd1,  // accepted level 0, input has been 1 for a while
    ST_HIGH      = 2'd2,  // accepted level 1, input agrees
    ST_WAIT_LOW  = 2'd3   // accepted level 1, input has been 0 for a while
  } state_t;

endpackage

// File: rtl/latch_input_debouncer_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   1-bit two-flop synchroniser. Brings an asynchronous level into the clk
//   domain; the first flop may go metastable, the second gives it a full
//   cycle to resolve.
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   synchronous active-high reset, clears both flops to 0
//     d    in   asynchronous input
//     q    out  synchronised output (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: reset is sampled on the clock edge here, so rst lives inside the
  // edge-triggered block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/latch_input_debouncer.sv
// ---------------------------------------------------------------------------
// latch_input_debouncer
//   Conditions a raw, possibly bouncing input (e.g. a switch) for a D latch:
//   d_out is the clean debounced level for the latch D input, en_pulse is a
//   single-cycle strobe for the latch En input that fires once per accepted
//   change, in the cycle where d_out already shows the new level.
//
//   A new level is accepted on the DEBOUNCE_CYCLES-th consecutive edge at
//   which the sampled input differs from d_out; any shorter excursion is
//   discarded silently.
//
//   Build option:
//     DEBOUNCE_SYNC_EN  defined   -> raw_in passes through a 2-flop
//                                    synchroniser before the FSM
//                       undefined -> raw_in is sampled directly (for inputs
//                                    already synchronous to clk)
//
//   Ports:
//     clk         in   system clock, rising edge
//     rst         in   synchronous active-high reset
//     raw_in      in   raw input level
//     d_out       out  debounced level (latch D)
//     en_pulse    out  one-cycle strobe on any accepted change (latch En)
//     rise_pulse  out  one-cycle strobe on accepted 0->1
//     fall_pulse  out  one-cycle strobe on accepted 1->0
// ---------------------------------------------------------------------------
module latch_input_debouncer
  import debounce_defs::*;
#(
  parameter  int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic d_out,
  output logic en_pulse,
  output logic rise_pulse,
  output logic fall_pulse
);

  // Count value at which the next disagreeing sample is the accepting one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (s)
  );
`else
  assign s = raw_in;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             d_nxt, rise_nxt, fall_nxt;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    d_nxt     = d_out;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    unique case (state)
      ST_LOW: begin
        cnt_nxt = '0;
        if (s) begin
          state_nxt = ST_WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end

      ST_WAIT_HIGH: begin
        if (!s) begin
          state_nxt = ST_LOW;  // glitch rejected, count discarded
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
          d_nxt     = 1'b1;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_HIGH: begin
        cnt_nxt = '0;
        if (!s) begin
          state_nxt = ST_WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end

      ST_WAIT_LOW: begin
        if (s) begin
          state_nxt = ST_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_LOW;
          cnt_nxt   = '0;
          d_nxt     = 1'b0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = ST_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // d_out and the strobes are registered on the same accepting edge, so the
  // latch sees D already stable for the whole cycle En is high.
  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_LOW;
      cnt        <= '0;
      d_out      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      en_pulse   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      d_out      <= d_nxt;
      rise_pulse <= rise_nxt;
      fall_pulse <= fall_nxt;
      en_pulse   <= rise_nxt | fall_nxt;
    end
  end

endmodule

// File: doc/latch_input_debouncer.md
Name: latch_input_debouncer

Overview:
- Upstream conditioning stage for the D latch. Takes one raw, asynchronous, possibly bouncing input such as a switch.
- Produces a clean, synchronised level `d_out` to drive the latch D input.
- Produces a one-cycle `en_pulse` to drive the latch En input. The pulse fires only when the debounced level changes, so the latch is loaded exactly once per accepted transition.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive sampled cycles the new level must persist before it is accepted. Legal range ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): stability counter width. Derived; not overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- raw_in  input  1  raw asynchronous input.
- d_out  output  1  debounced level; feeds latch D.
- en_pulse  output  1  one-cycle strobe on every accepted change; feeds latch En.
- rise_pulse  output  1  one-cycle strobe on accepted 0→1 change.
- fall_pulse  output  1  one-cycle strobe on accepted 1→0 change.

Behaviour:
- Reset (rst=1 at an edge):
  - sync flops ← 0, state ← ST_LOW, counter ← 0.
  - d_out=0, en_pulse=0, rise_pulse=0, fall_pulse=0.
  - Reset mid-count discards the count. There is no pulse on reset.
- Sampled signal `s`: output of the 2-flop synchroniser (see Optional Feature).
- FSM states and transitions:
  - ST_LOW: d_out=0, counter=0. If s=1 at an edge → ST_WAIT_HIGH, counter←1.
  - ST_WAIT_HIGH:
    - If s=0 → ST_LOW, counter←0. A glitch is rejected.
    - Else if counter==DEBOUNCE_CYCLES-1 → ST_HIGH, d_out←1, en_pulse←1, rise_pulse←1.
    - Else counter←counter+1.
  - ST_HIGH and ST_WAIT_LOW: mirror images of the above with levels inverted. The accepting edge drives fall_pulse←1.
- The accepting edge is the DEBOUNCE_CYCLES-th consecutive edge at which s differs from d_out.
- Pulse outputs are registered. Each is high for exactly one cycle, the cycle in which d_out already shows the new value, so the latch sees D stable while En is high.
- en_pulse = rise_pulse | fall_pulse, registered.
- Latency with sync: raw_in settles before edge k → d_out and en_pulse change at edge k+1+DEBOUNCE_CYCLES.
- Counter never exceeds DEBOUNCE_CYCLES-1. No wrap-around is possible.
- A bounce of any length < DEBOUNCE_CYCLES produces no output activity.
- Continuous toggling with period < DEBOUNCE_CYCLES holds d_out at its last accepted value indefinitely.
- Back-to-back accepted changes are separated by at least DEBOUNCE_CYCLES cycles, so pulses never merge.

Optional Feature:
- Macro DEBOUNCE_SYNC_EN.
  - Defined: raw_in passes through a 2-flop synchroniser; s = second flop.
  - Undefined: s = raw_in directly, for inputs already synchronous to clk. Latency becomes: raw_in stable before edge k → change at edge k+DEBOUNCE_CYCLES-1.
- All other behaviour is identical in both builds.

Decomposition:
- Shared header/package: debounce_defs.
  - State encodings ST_LOW=2'd0, ST_WAIT_HIGH=2'd1, ST_HIGH=2'd2, ST_WAIT_LOW=2'd3.
  - Default DEBOUNCE_CYCLES constant.
- Sub-module sync_2ff: 1-bit two-flop synchroniser with synchronous active-high reset to 0. Instantiated only under DEBOUNCE_SYNC_EN.
- FSM, counter and pulse registers stay in the top module.

Test Plan:
- Reset check:
  - Stimulus: DEBOUNCE_CYCLES=4, sync on; hold rst=1 for 3 cycles with raw_in=1.
  - Required: all outputs 0 throughout.
  - After release: d_out rises exactly 5 edges later, with a single en_pulse/rise_pulse.
- Clean rise:
  - Stimulus: raw_in 0→1 before edge 10, held.
  - Required: d_out=1 from edge 15; en_pulse and rise_pulse high only for the cycle after edge 15; fall_pulse stays 0.
- Glitch rejection:
  - Stimulus: from steady d_out=1, raw_in low for 3 cycles, then back high.
  - Required: d_out stays 1; no pulses on any pulse output.
- Bounce then settle:
  - Stimulus: raw_in toggles 1,0,1,0,1 on consecutive cycles, then stays 0.
  - Required: exactly one fall_pulse/en_pulse, 5 edges after the final settle; d_out=0.
- Reset mid-count:
  - Stimulus: raw_in high; assert rst for 1 cycle when the counter is 2.
  - Required: outputs 0 after the reset edge; the full count restarts; rise occurs 5 edges after rst deasserts.
- No-sync build:
  - Stimulus: DEBOUNCE_SYNC_EN undefined, DEBOUNCE_CYCLES=4; raw_in driven synchronously high before edge 20.
  - Required: d_out=1 and en_pulse high at edge 23.
